kernel_launch_seq: RTL and testbench

//  Sequences one OpenCL kernel launch over the kernel CRA slave of the *_system wrapper.
//  - Holds a table of 64-bit kernel arguments loaded by the host side.
//  - On launch, writes each argument as two 32-bit half writes, then the start word.
//  - Waits for kernel_irq, writes the IRQ acknowledge and reports completion.
//  - Sits between the host/test controller and the k_system avs_k_cra_* port.

---
 rtl/kernel_launch_seq.sv | 178 +++++++++++++++++
 tb/tb_kernel_launch_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_launch_seq.sv
// kernel_launch_seq: drives one OpenCL kernel launch over the kernel CRA slave.
// Arguments are staged in a local table, written as low/high 32-bit halves,
// followed by the start word; the sequencer then waits for kernel_irq,
// acknowledges it and pulses done. A GAP state always separates two strobes.
module kernel_launch_seq #(
  parameter int unsigned NUM_ARGS       = 11,
  parameter logic [7:0]  ARG_BASE_ADDR  = 8'h05,
  parameter logic [7:0]  START_ADDR     = 8'h00,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        arg_wr_en,
  input  logic [3:0]  arg_idx,
  input  logic [63:0] arg_data,
  input  logic        launch,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        cra_write,
  output logic [7:0]  cra_address,
  output logic [63:0] cra_writedata,
  output logic [7:0]  cra_byteenable,
  input  logic        cra_waitrequest,
  input  logic        kernel_irq
);

  typedef enum logic [2:0] {
    IDLE, ARG_LO, ARG_HI, GAP, START, WAIT_IRQ, ACK, FIN
  } state_t;

  // Last slot index, slot count for range checks, final GAP count value
  // (a zero-length gap still spends one idle cycle so strobes never touch)
  // and the WAIT_IRQ count at which the timeout fires.
  localparam logic [3:0]  LAST_SLOT    = 4'(NUM_ARGS - 1);
  localparam logic [4:0]  NUM_ARGS_W   = 5'(NUM_ARGS);
  localparam logic [7:0]  GAP_LAST     = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

  state_t      state_r;
  state_t      last_r;       // write state that preceded the current GAP
  logic [3:0]  slot_r;
  logic [7:0]  gap_cnt_r;
  logic [31:0] wait_cnt_r;
  logic [63:0] args_r [16];

  logic        arg_ok_s;
  logic [63:0] launch_data_s;
  logic [3:0]  next_slot_s;
  logic [7:0]  next_addr_s;

  // An in-range argument load; a load to slot 0 together with launch must be
  // seen by the very first write, so bypass the table for that case.
  assign arg_ok_s      = arg_wr_en && ({1'b0, arg_idx} < NUM_ARGS_W);
  assign launch_data_s = (arg_ok_s && (arg_idx == 4'd0)) ? arg_data : args_r[0];
  assign next_slot_s   = slot_r + 4'd1;
  assign next_addr_s   = ARG_BASE_ADDR + {4'd0, next_slot_s};

  // Launch sequencer: state, argument table and all registered outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r        <= IDLE;
      last_r         <= IDLE;
      slot_r         <= 4'd0;
      gap_cnt_r      <= 8'd0;
      wait_cnt_r     <= 32'd0;
      args_r         <= '{default: 64'h0};
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout_err    <= 1'b0;
      cra_write      <= 1'b0;
      cra_address    <= 8'h00;
      cra_writedata  <= 64'h0;
      cra_byteenable <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (arg_ok_s) begin
            args_r[arg_idx] <= arg_data;
          end
          if (launch) begin
            state_r        <= ARG_LO;
            busy           <= 1'b1;
            timeout_err    <= 1'b0;
            slot_r         <= 4'd0;
            cra_write      <= 1'b1;
            cra_address    <= ARG_BASE_ADDR;
            cra_writedata  <= launch_data_s;
            cra_byteenable <= 8'h0F;
          end
        end
        ARG_LO, ARG_HI, START, ACK: begin
          // Strobe and payload stay frozen until the slave stops stalling.
          if (!cra_waitrequest) begin
            cra_write <= 1'b0;
            last_r    <= state_r;
            gap_cnt_r <= 8'd0;
            state_r   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_r >= GAP_LAST) begin
            case (last_r)
              ARG_LO: begin
                state_r        <= ARG_HI;
                cra_write      <= 1'b1;
                cra_byteenable <= 8'hF0;
              end
              ARG_HI: begin
                if (slot_r == LAST_SLOT) begin
                  state_r        <= START;
                  cra_write      <= 1'b1;
                  cra_address    <= START_ADDR;
                  cra_writedata  <= 64'h1;
                  cra_byteenable <= 8'h0F;
                end else begin
                  state_r        <= ARG_LO;
                  slot_r         <= next_slot_s;
                  cra_write      <= 1'b1;
                  cra_address    <= next_addr_s;
                  cra_writedata  <= args_r[next_slot_s];
                  cra_byteenable <= 8'h0F;
                end
              end
              START: begin
                state_r    <= WAIT_IRQ;
                wait_cnt_r <= 32'd0;
              end
              ACK: begin
                state_r <= FIN;
                done    <= 1'b1;
                busy    <= 1'b0;
              end
              default: begin
                state_r   <= IDLE;
                busy      <= 1'b0;
                cra_write <= 1'b0;
              end
            endcase
          end else begin
            gap_cnt_r <= gap_cnt_r + 8'd1;
          end
        end
        WAIT_IRQ: begin
          // A pending interrupt takes priority over an expiring timeout.
          if (kernel_irq) begin
            state_r        <= ACK;
            cra_write      <= 1'b1;
            cra_address    <= START_ADDR;
            cra_writedata  <= 64'h0;
            cra_byteenable <= 8'h0F;
          end else if (TIMEOUT_EN && (wait_cnt_r == TIMEOUT_LAST)) begin
            state_r     <= FIN;
            timeout_err <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
          end else begin
            wait_cnt_r <= wait_cnt_r + 32'd1;
          end
        end
        FIN: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          cra_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_launch_seq.sv
// tb_kernel_launch_seq: directed bench for kernel_launch_seq with a
// transaction-level reference model checked on every cycle.
module tb_kernel_launch_seq;

  localparam int NA   = 11;
  localparam int W    = 2;
  localparam int TO   = 100;
  localparam int GAPN = (W == 0) ? 1 : W;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        arg_wr_en = 1'b0;
  logic [3:0]  arg_idx = 4'd0;
  logic [63:0] arg_data = 64'h0;
  logic        launch = 1'b0;
  logic        cra_waitrequest = 1'b0;
  logic        kernel_irq = 1'b0;
  logic        busy, done, timeout_err, cra_write;
  logic [7:0]  cra_address, cra_byteenable;
  logic [63:0] cra_writedata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int hold_cnt = 0;
  logic [79:0] wlog[$];

  kernel_launch_seq #(
    .NUM_ARGS(11), .ARG_BASE_ADDR(8'h05), .START_ADDR(8'h00),
    .GAP_CYCLES(2), .TIMEOUT_CYCLES(100)
  ) dut (
    .clock(clock), .resetn(resetn), .arg_wr_en(arg_wr_en), .arg_idx(arg_idx),
    .arg_data(arg_data), .launch(launch), .busy(busy), .done(done),
    .timeout_err(timeout_err), .cra_write(cra_write), .cra_address(cra_address),
    .cra_writedata(cra_writedata), .cra_byteenable(cra_byteenable),
    .cra_waitrequest(cra_waitrequest), .kernel_irq(kernel_irq)
  );

  always #5 clock = ~clock;

  // Edge counter used to schedule stimulus and measure latency.
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic        m_busy, m_done, m_terr, m_write;
  logic [7:0]  m_addr, m_be;
  logic [63:0] m_data;
  logic [63:0] m_args [16];
  bit          m_ab;

  task automatic m_step();
    @(posedge clock);
    if (!resetn) m_ab = 1'b1;
  endtask

  task automatic m_clear();
    m_busy = 1'b0; m_done = 1'b0; m_terr = 1'b0; m_write = 1'b0;
    m_addr = 8'h00; m_be = 8'h00; m_data = 64'h0; m_ab = 1'b0;
    for (int i = 0; i < 16; i++) m_args[i] = 64'h0;
  endtask

  // One CRA write: strobe until an edge without stall, then the idle gap.
  task automatic m_txn(input logic [7:0] a, input logic [63:0] d, input logic [7:0] b);
    bit acc;
    m_write = 1'b1; m_addr = a; m_data = d; m_be = b;
    acc = 1'b0;
    while (!acc) begin
      m_step();
      if (m_ab) return;
      acc = !cra_waitrequest;
    end
    m_write = 1'b0;
    for (int g = 0; g < GAPN; g++) begin
      m_step();
      if (m_ab) return;
    end
  endtask

  task automatic m_run();
    int n;
    bit irq_seen;
    m_busy = 1'b1; m_terr = 1'b0;
    for (int s = 0; s < NA; s++) begin
      m_txn(8'h05 + 8'(s), m_args[s], 8'h0F);
      if (m_ab) return;
      m_txn(8'h05 + 8'(s), m_args[s], 8'hF0);
      if (m_ab) return;
    end
    m_txn(8'h00, 64'h1, 8'h0F);
    if (m_ab) return;
    n = 0; irq_seen = 1'b0;
    forever begin
      m_step();
      if (m_ab) return;
      if (kernel_irq) begin irq_seen = 1'b1; break; end
      if (TO != 0 && n == TO - 1) break;
      n++;
    end
    if (irq_seen) begin
      m_txn(8'h00, 64'h0, 8'h0F);
      if (m_ab) return;
    end else begin
      m_terr = 1'b1;
    end
    m_done = 1'b1; m_busy = 1'b0;
    m_step();
    if (m_ab) return;
    m_done = 1'b0;
  endtask

  // Model main loop: loads, launches and resets as seen at each edge.
  initial begin
    m_clear();
    forever begin
      m_step();
      if (m_ab) begin m_clear(); continue; end
      if (arg_wr_en && arg_idx < NA) m_args[arg_idx] = arg_data;
      if (launch) begin
        m_run();
        if (m_ab) m_clear();
      end
    end
  end

  // Per-cycle compare against the model plus write log and done tracking.
  initial begin
    logic [3:0] act_f, exp_f;
    bit bad;
    forever begin
      @(negedge clock);
      checks++;
      act_f = {busy, done, timeout_err, cra_write};
      exp_f = {m_busy, m_done, m_terr, m_write};
      bad = (act_f !== exp_f);
      if (m_write && ({cra_address, cra_writedata, cra_byteenable} !== {m_addr, m_data, m_be})) bad = 1'b1;
      if (bad) begin
        errors++;
        $display("FAIL cycle %0d outputs: got busy/done/terr/wr=%b addr=%h data=%h be=%h, expected %b addr=%h data=%h be=%h",
                 cyc, act_f, cra_address, cra_writedata, cra_byteenable, exp_f, m_addr, m_data, m_be);
      end
      if (done) begin done_cnt++; last_done_cyc = cyc; end
      if (cra_write && cra_address == 8'h06 && cra_byteenable == 8'hF0) hold_cnt++;
      if (resetn && cra_write && !cra_waitrequest) wlog.push_back({cra_address, cra_writedata, cra_byteenable});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] pk(input logic [7:0] a, input logic [63:0] d, input logic [7:0] b);
    return {a, d, b};
  endfunction

  function automatic logic [79:0] getlog(input int k);
    if (k < wlog.size()) return wlog[k];
    else return '1;
  endfunction

  task automatic wait_done(input int base, input int limit);
    int n;
    n = 0;
    while (done_cnt == base && n < limit) begin tick(); n++; end
    chk("done_seen", 80'(done_cnt != base), 80'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int c0, lb, d0, h0;
    repeat (3) tick();
    chk("reset_flags", {76'd0, busy, done, timeout_err, cra_write}, 80'd0);
    chk("reset_bus", {cra_address, cra_writedata, cra_byteenable}, 80'd0);
    resetn = 1'b1;
    tick();

    // 1: args[i]=i+1, out-of-range load, irq 50 cycles after start accepted
    for (int i = 0; i < NA; i++) begin
      arg_wr_en = 1'b1; arg_idx = 4'(i); arg_data = 64'(i + 1); tick();
    end
    arg_idx = 4'd12; arg_data = 64'hBAD; tick();
    arg_wr_en = 1'b0;
    lb = wlog.size(); d0 = done_cnt; c0 = cyc;
    launch = 1'b1; tick(); launch = 1'b0;
    wait_until(c0 + 118); kernel_irq = 1'b1;
    wait_done(d0, 400);
    kernel_irq = 1'b0;
    repeat (4) tick();
    chk("t1_count", 80'(wlog.size() - lb), 80'd24);
    chk("t1_w0", getlog(lb), pk(8'h05, 64'd1, 8'h0F));
    chk("t1_w1", getlog(lb + 1), pk(8'h05, 64'd1, 8'hF0));
    chk("t1_w2", getlog(lb + 2), pk(8'h06, 64'd2, 8'h0F));
    chk("t1_w21", getlog(lb + 21), pk(8'h0F, 64'd11, 8'hF0));
    chk("t1_start", getlog(lb + 22), pk(8'h00, 64'd1, 8'h0F));
    chk("t1_ack", getlog(lb + 23), pk(8'h00, 64'd0, 8'h0F));
    chk("t1_done_once", 80'(done_cnt - d0), 80'd1);
    chk("t1_latency", 80'(last_done_cyc - c0), 80'd122);

    // 2+4: stall on 4th write, launch and load while busy
    lb = wlog.size(); d0 = done_cnt; h0 = hold_cnt; c0 = cyc;
    launch = 1'b1; tick(); launch = 1'b0;
    wait_until(c0 + 10); cra_waitrequest = 1'b1;
    wait_until(c0 + 13); cra_waitrequest = 1'b0;
    wait_until(c0 + 20);
    launch = 1'b1; arg_wr_en = 1'b1; arg_idx = 4'd3; arg_data = 64'hFFFF;
    tick();
    launch = 1'b0; arg_wr_en = 1'b0;
    wait_until(c0 + 90); kernel_irq = 1'b1;
    wait_done(d0, 400);
    kernel_irq = 1'b0;
    repeat (4) tick();
    chk("t2_count", 80'(wlog.size() - lb), 80'd24);
    chk("t2_hold_cycles", 80'(hold_cnt - h0), 80'd4);
    chk("t2_w3", getlog(lb + 3), pk(8'h06, 64'd2, 8'hF0));
    chk("t4_slot3_kept", getlog(lb + 7), pk(8'h08, 64'd4, 8'hF0));
    chk("t4_done_once", 80'(done_cnt - d0), 80'd1);
    chk("t4_idle", {79'd0, busy}, 80'd0);

    // 3: timeout without irq, then next launch clears timeout_err
    lb = wlog.size(); d0 = done_cnt; c0 = cyc;
    launch = 1'b1; tick(); launch = 1'b0;
    wait_done(d0, 400);
    chk("t3_terr", {79'd0, timeout_err}, 80'd1);
    chk("t3_count", 80'(wlog.size() - lb), 80'd23);
    chk("t3_last", getlog(lb + 22), pk(8'h00, 64'd1, 8'h0F));
    chk("t3_latency", 80'(last_done_cyc - c0), 80'd170);
    d0 = done_cnt;
    launch = 1'b1; tick(); launch = 1'b0;
    chk("t3_relaunch", {78'd0, busy, timeout_err}, 80'd2);
    kernel_irq = 1'b1;
    wait_done(d0, 400);
    kernel_irq = 1'b0;
    repeat (3) tick();

    // 5: reset during ARG_HI of slot 3
    lb = wlog.size(); c0 = cyc;
    launch = 1'b1; tick(); launch = 1'b0;
    wait_until(c0 + 22);
    chk("t5_pre_reset", {64'd0, cra_address, cra_byteenable}, {64'd0, 8'h08, 8'hF0});
    resetn = 1'b0; tick();
    chk("t5_after_reset", {77'd0, busy, done, cra_write}, 80'd0);
    chk("t5_partial", 80'(wlog.size() - lb), 80'd7);
    resetn = 1'b1; tick();

    // 6: load slot 0 with launch, irq already high
    kernel_irq = 1'b1;
    lb = wlog.size(); d0 = done_cnt; c0 = cyc;
    arg_wr_en = 1'b1; arg_idx = 4'd0; arg_data = 64'hDEAD; launch = 1'b1;
    tick();
    arg_wr_en = 1'b0; launch = 1'b0;
    wait_done(d0, 400);
    kernel_irq = 1'b0;
    repeat (3) tick();
    chk("t6_count", 80'(wlog.size() - lb), 80'd24);
    chk("t6_w0", getlog(lb), pk(8'h05, 64'hDEAD, 8'h0F));
    chk("t6_w1", getlog(lb + 1), pk(8'h05, 64'hDEAD, 8'hF0));
    chk("t6_args_cleared", getlog(lb + 2), pk(8'h06, 64'd0, 8'h0F));
    chk("t6_ack", getlog(lb + 23), pk(8'h00, 64'd0, 8'h0F));
    chk("t6_latency", 80'(last_done_cyc - c0), 80'd74);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
